// File: rtl/fp_prenorm_stage_pkg.sv
// Shared types for the FP pre-normalisation stage: opcode, thread index and
// the per-lane flag bundle produced by fp_prenorm_lane.
package fp_prenorm_stage_pkg;

  typedef enum logic [1:0] {
    FP_ADD = 2'd0,
    FP_SUB = 2'd1,
    FP_CMP = 2'd2,
    FP_MUL = 2'd3
  } fp_op_t;

  localparam int THREAD_IDX_W = 3;
  typedef logic [THREAD_IDX_W-1:0] thread_idx_t;

  typedef struct packed {
    logic logical_sub;
    logic add_sign;
    logic result_nan;
    logic result_inf;
    logic mul_sign;
    logic mul_underflow;
  } fp_prenorm_lane_t;

endpackage

// File: rtl/fp_prenorm_stage_lane.sv
// Combinational pre-normalisation of one lane: operand ordering and alignment
// for add/sub/cmp, exponent sum for mul, and special-value classification.
module fp_prenorm_lane
  import fp_prenorm_stage_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int SHW    = $clog2(FRAC_W + 5)
) (
  input  fp_op_t               op,
  input  logic                 ftz,
  input  logic [EXP_W+FRAC_W:0] operand1,
  input  logic [EXP_W+FRAC_W:0] operand2,
  output logic [FRAC_W:0]      sig_le,
  output logic [FRAC_W:0]      sig_se,
  output logic [SHW-1:0]       align_shift,
  output logic [EXP_W-1:0]     add_exp,
  output logic [EXP_W-1:0]     mul_exp,
  output logic [FRAC_W:0]      multiplicand,
  output logic [FRAC_W:0]      multiplier,
  output fp_prenorm_lane_t     flags
);

  localparam int BIAS      = (1 << (EXP_W - 1)) - 1;
  localparam int MAX_SHIFT = FRAC_W + 4;
  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic signed [EXP_W+1:0] MUL_BIAS = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] MUL_INF  = (EXP_W+2)'((1 << EXP_W) - 1);

  logic                     s1, s2;
  logic [EXP_W-1:0]         e1, e2, e_diff;
  logic [FRAC_W-1:0]        f1, f2;
  logic [FRAC_W:0]          sig1, sig2;
  logic                     op1_larger;
  logic signed [EXP_W+1:0]  mul_sum;
  logic                     mul_uf, mul_ovf;
  logic                     nan1, nan2, inf1, inf2, zero1, zero2, any_nan;

  assign s1 = operand1[EXP_W+FRAC_W];
  assign s2 = operand2[EXP_W+FRAC_W];
  assign e1 = operand1[FRAC_W +: EXP_W];
  assign e2 = operand2[FRAC_W +: EXP_W];
  assign f1 = operand1[FRAC_W-1:0];
  assign f2 = operand2[FRAC_W-1:0];

  // Flush-to-zero removes the stored fraction of subnormals entirely.
  assign sig1 = (ftz && (e1 == '0)) ? '0 : {e1 != '0, f1};
  assign sig2 = (ftz && (e2 == '0)) ? '0 : {e2 != '0, f2};

  assign op1_larger = (e1 > e2) || ((e1 == e2) && (sig1 >= sig2));

  assign nan1  = (e1 == EXP_ONES) && (f1 != '0);
  assign nan2  = (e2 == EXP_ONES) && (f2 != '0);
  assign inf1  = (e1 == EXP_ONES) && (f1 == '0);
  assign inf2  = (e2 == EXP_ONES) && (f2 == '0);
  assign zero1 = (sig1 == '0);
  assign zero2 = (sig2 == '0);

  assign mul_sum = $signed({2'b00, e1}) + $signed({2'b00, e2}) - MUL_BIAS;
  assign mul_uf  = mul_sum[EXP_W+1] || (mul_sum == '0);
  assign mul_ovf = !mul_sum[EXP_W+1] && (mul_sum >= MUL_INF);

  assign sig_le       = op1_larger ? sig1 : sig2;
  assign sig_se       = op1_larger ? sig2 : sig1;
  assign add_exp      = op1_larger ? e1 : e2;
  assign e_diff       = op1_larger ? (e1 - e2) : (e2 - e1);
  assign align_shift  = (int'(e_diff) > MAX_SHIFT) ? SHW'(MAX_SHIFT) : SHW'(e_diff);
  assign mul_exp      = mul_uf ? '0 : mul_sum[EXP_W-1:0];
  assign multiplicand = sig1;
  assign multiplier   = sig2;

  always_comb begin
    flags               = '0;
    flags.logical_sub   = s1 ^ s2 ^ (op != FP_ADD);
    flags.add_sign      = op1_larger ? s1 : (s2 ^ ((op == FP_SUB) || (op == FP_CMP)));
    flags.mul_sign      = s1 ^ s2;
    flags.mul_underflow = mul_uf;
    any_nan = nan1 || nan2;
    if (op == FP_MUL) begin
      any_nan = any_nan || (inf1 && zero2) || (inf2 && zero1);
    end else begin
      any_nan = any_nan || (inf1 && inf2 && flags.logical_sub);
    end
    flags.result_nan = any_nan;
    flags.result_inf = !any_nan && (inf1 || inf2 || ((op == FP_MUL) && mul_ovf));
  end

endmodule

// File: rtl/fp_prenorm_stage.sv
// Registered vector FP pre-normalisation stage with a two-entry output/skid
// buffer and per-thread rollback squash.
module fp_prenorm_stage
  import fp_prenorm_stage_pkg::*;
#(
  parameter int  LANES  = 16,
  parameter int  EXP_W  = 8,
  parameter int  FRAC_W = 23,
  localparam int OPW    = 1 + EXP_W + FRAC_W,
  localparam int SHW    = $clog2(FRAC_W + 5),
  localparam int SW     = FRAC_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  fp_op_t                 in_op,
  input  thread_idx_t            in_thread_idx,
  input  logic [LANES-1:0]       in_mask,
  input  logic                   in_ftz,
  input  logic [LANES*OPW-1:0]   in_operand1,
  input  logic [LANES*OPW-1:0]   in_operand2,
  input  logic                   rollback_en,
  input  thread_idx_t            rollback_thread_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output fp_op_t                 out_op,
  output thread_idx_t            out_thread_idx,
  output logic [LANES-1:0]       out_mask,
  output logic [LANES*SW-1:0]    sig_le,
  output logic [LANES*SW-1:0]    sig_se,
  output logic [LANES*SHW-1:0]   align_shift,
  output logic [LANES*EXP_W-1:0] add_exp,
  output logic [LANES-1:0]       logical_sub,
  output logic [LANES-1:0]       add_sign,
  output logic [LANES-1:0]       result_nan,
  output logic [LANES-1:0]       result_inf,
  output logic [LANES*EXP_W-1:0] mul_exp,
  output logic [LANES-1:0]       mul_sign,
  output logic [LANES-1:0]       mul_underflow,
  output logic [LANES*SW-1:0]    multiplicand,
  output logic [LANES*SW-1:0]    multiplier
);

  localparam int LD = 4*SW + SHW + 2*EXP_W + $bits(fp_prenorm_lane_t);

  // Handshake: a beat moves on a side only in a cycle where valid and ready are
  // both high at posedge clk; a valid side holds its payload until that happens.
  logic [LANES*LD-1:0] in_data, out_data, skid_data;
  logic                skid_valid;
  fp_op_t              skid_op;
  thread_idx_t         skid_thread_idx;
  logic [LANES-1:0]    skid_mask;

  logic in_kill, out_kill, skid_kill, accept, out_free, skid_live;
  logic out_load_skid, out_load_in, skid_load, out_valid_d, skid_valid_d;

  assign in_ready = !skid_valid;

  assign in_kill   = rollback_en && (in_thread_idx == rollback_thread_idx);
  assign out_kill  = rollback_en && out_valid && (out_thread_idx == rollback_thread_idx);
  assign skid_kill = rollback_en && skid_valid && (skid_thread_idx == rollback_thread_idx);
  assign accept    = in_valid && in_ready && !in_kill;
  assign out_free  = !out_valid || out_ready || out_kill;
  assign skid_live = skid_valid && !skid_kill;

  // The skid slot only ever fills while the output slot is held, so a live
  // skid entry and an accept are mutually exclusive.
  always_comb begin
    out_load_skid = 1'b0;
    out_load_in   = 1'b0;
    skid_load     = 1'b0;
    out_valid_d   = out_valid;
    skid_valid_d  = 1'b0;
    if (out_free) begin
      out_valid_d = skid_live || accept;
      if (skid_live) out_load_skid = 1'b1;
      else if (accept) out_load_in = 1'b1;
    end else if (skid_live) begin
      skid_valid_d = 1'b1;
    end else if (accept) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      skid_valid     <= 1'b0;
      out_op         <= FP_ADD;
      out_thread_idx <= '0;
      out_mask       <= '0;
    end else begin
      out_valid  <= out_valid_d;
      skid_valid <= skid_valid_d;
      if (out_load_skid) begin
        out_op         <= skid_op;
        out_thread_idx <= skid_thread_idx;
        out_mask       <= skid_mask;
      end else if (out_load_in) begin
        out_op         <= in_op;
        out_thread_idx <= in_thread_idx;
        out_mask       <= in_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (out_load_skid) out_data <= skid_data;
    else if (out_load_in) out_data <= in_data;
    if (skid_load) begin
      skid_data       <= in_data;
      skid_op         <= in_op;
      skid_thread_idx <= in_thread_idx;
      skid_mask       <= in_mask;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SW-1:0]    l_sig_le, l_sig_se, l_mcand, l_mplier;
    logic [SHW-1:0]   l_shift;
    logic [EXP_W-1:0] l_add_exp, l_mul_exp;
    fp_prenorm_lane_t l_flags, o_flags;

    fp_prenorm_lane #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .SHW(SHW)) u_lane (
      .op           (in_op),
      .ftz          (in_ftz),
      .operand1     (in_operand1[l*OPW +: OPW]),
      .operand2     (in_operand2[l*OPW +: OPW]),
      .sig_le       (l_sig_le),
      .sig_se       (l_sig_se),
      .align_shift  (l_shift),
      .add_exp      (l_add_exp),
      .mul_exp      (l_mul_exp),
      .multiplicand (l_mcand),
      .multiplier   (l_mplier),
      .flags        (l_flags)
    );

    assign in_data[l*LD +: LD] = {l_sig_le, l_sig_se, l_shift, l_add_exp,
                                  l_mul_exp, l_mcand, l_mplier, l_flags};

    assign {sig_le[l*SW +: SW], sig_se[l*SW +: SW], align_shift[l*SHW +: SHW],
            add_exp[l*EXP_W +: EXP_W], mul_exp[l*EXP_W +: EXP_W],
            multiplicand[l*SW +: SW], multiplier[l*SW +: SW], o_flags} = out_data[l*LD +: LD];

    assign logical_sub[l]   = o_flags.logical_sub;
    assign add_sign[l]      = o_flags.add_sign;
    assign result_nan[l]    = o_flags.result_nan;
    assign result_inf[l]    = o_flags.result_inf;
    assign mul_sign[l]      = o_flags.mul_sign;
    assign mul_underflow[l] = o_flags.mul_underflow;
  end

endmodule

// File: tb/tb_fp_prenorm_stage.sv
// Directed bench for fp_prenorm_stage: single-precision instance for datapath,
// buffering and rollback, plus a half-precision instance for parameterisation.
module tb_fp_prenorm_stage;
  import fp_prenorm_stage_pkg::*;

  localparam int LANES = 16;
  localparam int SBW   = 3 + LANES + 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic in_valid, in_ready, in_ftz, rollback_en, out_valid, out_ready;
  fp_op_t in_op, out_op;
  thread_idx_t in_thread_idx, rollback_thread_idx, out_thread_idx;
  logic [LANES-1:0] in_mask, out_mask;
  logic [LANES*32-1:0] in_operand1, in_operand2;
  logic [LANES*24-1:0] sig_le, sig_se, multiplicand, multiplier;
  logic [LANES*5-1:0]  align_shift;
  logic [LANES*8-1:0]  add_exp, mul_exp;
  logic [LANES-1:0] logical_sub, add_sign, result_nan, result_inf, mul_sign, mul_underflow;

  fp_prenorm_stage #(.LANES(LANES)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_thread_idx(in_thread_idx), .in_mask(in_mask), .in_ftz(in_ftz),
    .in_operand1(in_operand1), .in_operand2(in_operand2),
    .rollback_en(rollback_en), .rollback_thread_idx(rollback_thread_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_thread_idx(out_thread_idx), .out_mask(out_mask),
    .sig_le(sig_le), .sig_se(sig_se), .align_shift(align_shift), .add_exp(add_exp),
    .logical_sub(logical_sub), .add_sign(add_sign), .result_nan(result_nan),
    .result_inf(result_inf), .mul_exp(mul_exp), .mul_sign(mul_sign),
    .mul_underflow(mul_underflow), .multiplicand(multiplicand), .multiplier(multiplier)
  );

  logic h_in_valid, h_in_ready, h_in_ftz, h_out_valid, h_out_ready;
  fp_op_t h_in_op, h_out_op;
  thread_idx_t h_in_thread_idx, h_out_thread_idx;
  logic h_in_mask, h_out_mask;
  logic [15:0] h_in_operand1, h_in_operand2;
  logic [10:0] h_sig_le, h_sig_se, h_multiplicand, h_multiplier;
  logic [3:0]  h_align_shift;
  logic [4:0]  h_add_exp, h_mul_exp;
  logic h_logical_sub, h_add_sign, h_result_nan, h_result_inf, h_mul_sign, h_mul_underflow;

  fp_prenorm_stage #(.LANES(1), .EXP_W(5), .FRAC_W(10)) dut_h (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_op(h_in_op), .in_thread_idx(h_in_thread_idx), .in_mask(h_in_mask), .in_ftz(h_in_ftz),
    .in_operand1(h_in_operand1), .in_operand2(h_in_operand2),
    .rollback_en(1'b0), .rollback_thread_idx(3'd0),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_op(h_out_op),
    .out_thread_idx(h_out_thread_idx), .out_mask(h_out_mask),
    .sig_le(h_sig_le), .sig_se(h_sig_se), .align_shift(h_align_shift), .add_exp(h_add_exp),
    .logical_sub(h_logical_sub), .add_sign(h_add_sign), .result_nan(h_result_nan),
    .result_inf(h_result_inf), .mul_exp(h_mul_exp), .mul_sign(h_mul_sign),
    .mul_underflow(h_mul_underflow), .multiplicand(h_multiplicand), .multiplier(h_multiplier)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [SBW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input fp_op_t op, input thread_idx_t tid, input logic [LANES-1:0] mask,
                            input logic [31:0] a, input logic [31:0] b, input logic ftz);
    in_valid      = 1'b1;
    in_op         = op;
    in_thread_idx = tid;
    in_mask       = mask;
    in_ftz        = ftz;
    in_operand1   = {LANES{a}};
    in_operand2   = {LANES{b}};
  endtask

  // One beat through an unstalled pipe; results are on the outputs on return.
  task automatic run_one(input fp_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic ftz);
    out_ready = 1'b1;
    drive_beat(op, 3'd5, 16'h0001, a, b, ftz);
    step();
    in_valid = 1'b0;
    check("beat_valid", out_valid, 1'b1);
  endtask

  initial begin
    int sent, got, cyc;
    bit stall_checked;
    logic [SBW-1:0] exp_e;
    reset = 1'b1;
    in_valid = 1'b0; in_op = FP_ADD; in_thread_idx = '0; in_mask = '0; in_ftz = 1'b0;
    in_operand1 = '0; in_operand2 = '0; rollback_en = 1'b0; rollback_thread_idx = '0;
    out_ready = 1'b0;
    h_in_valid = 1'b0; h_in_op = FP_ADD; h_in_thread_idx = '0; h_in_mask = 1'b0;
    h_in_ftz = 1'b0; h_in_operand1 = '0; h_in_operand2 = '0; h_out_ready = 1'b1;

    repeat (2) step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_mask", out_mask, '0);
    check("rst_out_thread", out_thread_idx, '0);
    reset = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1'b1);

    // 1.0 + 2.0: op2 is larger, one-bit alignment
    run_one(FP_ADD, 32'h3F800000, 32'h40000000, 1'b0);
    check("add_sig_le", sig_le[23:0], 24'h800000);
    check("add_sig_se", sig_se[23:0], 24'h800000);
    check("add_exp", add_exp[7:0], 8'd128);
    check("add_shift", align_shift[4:0], 5'd1);
    check("add_lsub", logical_sub[0], 1'b0);
    check("add_sign", add_sign[0], 1'b0);
    check("add_masked_lane_exp", add_exp[(LANES-1)*8 +: 8], 8'd128);
    check("add_out_thread", out_thread_idx, 3'd5);
    check("add_out_mask", out_mask, 16'h0001);

    run_one(FP_SUB, 32'h7F800000, 32'h7F800000, 1'b0);
    check("sub_inf_nan", result_nan[0], 1'b1);
    check("sub_inf_inf", result_inf[0], 1'b0);
    check("sub_op", out_op, FP_SUB);

    run_one(FP_MUL, 32'h7F800000, 32'h00000000, 1'b0);
    check("mul_inf0_nan", result_nan[0], 1'b1);

    run_one(FP_MUL, 32'h7F000000, 32'h7F000000, 1'b0);
    check("mul_ovf_inf", result_inf[0], 1'b1);
    check("mul_ovf_nan", result_nan[0], 1'b0);

    run_one(FP_MUL, 32'h00800000, 32'h00800000, 1'b0);
    check("mul_uf_flag", mul_underflow[0], 1'b1);
    check("mul_uf_exp", mul_exp[7:0], 8'd0);

    // -1.5 x 2.0: exponent 127+128-127, negative product
    run_one(FP_MUL, 32'hBFC00000, 32'h40000000, 1'b0);
    check("mul_exp", mul_exp[7:0], 8'd128);
    check("mul_sign", mul_sign[0], 1'b1);
    check("mul_mcand", multiplicand[23:0], 24'hC00000);

    run_one(FP_MUL, 32'h00400000, 32'h3F800000, 1'b1);
    check("ftz_mcand", multiplicand[23:0], 24'h000000);
    run_one(FP_MUL, 32'h00400000, 32'h3F800000, 1'b0);
    check("noftz_mcand", multiplicand[23:0], 24'h400000);

    run_one(FP_ADD, 32'h7F000000, 32'h3F800000, 1'b0);
    check("clamp_shift", align_shift[4:0], 5'd27);
    check("clamp_exp", add_exp[7:0], 8'd254);

    run_one(FP_SUB, 32'h3F800000, 32'h40000000, 1'b0);
    check("sub_swap_sign", add_sign[0], 1'b1);
    check("sub_swap_lsub", logical_sub[0], 1'b1);

    // 1.0 + -1.0: equal magnitudes keep op1 in the larger slot
    run_one(FP_ADD, 32'h3F800000, 32'hBF800000, 1'b0);
    check("tie_sign", add_sign[0], 1'b0);
    check("tie_lsub", logical_sub[0], 1'b1);

    step();
    check("drain_empty", out_valid, 1'b0);

    // Four beats against a three-cycle output stall
    out_ready = 1'b0;
    sent = 0; got = 0; cyc = 0; stall_checked = 1'b0;
    while ((got < 4) && (cyc < 50)) begin
      if (sent < 4)
        drive_beat(FP_ADD, thread_idx_t'(sent + 1), 16'h0001 << sent,
                   32'h3F800000 + (32'(sent) << 23), 32'h3F800000, 1'b0);
      else
        in_valid = 1'b0;
      out_ready = (cyc >= 3);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL stream_underrun: got an output beat, expected none pending");
        end else begin
          exp_e = exp_q.pop_front();
          check("stream_beat", {out_thread_idx, out_mask, add_exp[7:0]}, exp_e);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({thread_idx_t'(sent + 1), 16'h0001 << sent, 8'(127 + sent)});
        sent++;
      end
      step();
      cyc++;
      if ((sent == 2) && !stall_checked) begin
        check("stall_in_ready", in_ready, 1'b0);
        stall_checked = 1'b1;
      end
    end
    in_valid = 1'b0;
    check("stream_count", got, 4);
    check("stream_sent", sent, 4);

    // Rollback with threads 1 (output) and 2 (skid) held
    out_ready = 1'b0;
    drive_beat(FP_ADD, 3'd1, 16'h0010, 32'h3F800000, 32'h3F800000, 1'b0);
    step();
    drive_beat(FP_ADD, 3'd2, 16'h0020, 32'h3F800000, 32'h3F800000, 1'b0);
    step();
    in_valid = 1'b0;
    check("rb_pre_in_ready", in_ready, 1'b0);
    rollback_en = 1'b1; rollback_thread_idx = 3'd1;
    step();
    check("rb_out_valid", out_valid, 1'b1);
    check("rb_out_thread", out_thread_idx, 3'd2);
    check("rb_out_mask", out_mask, 16'h0020);
    check("rb_in_ready", in_ready, 1'b1);
    // A squashed incoming beat must not land in the skid slot
    rollback_thread_idx = 3'd3;
    drive_beat(FP_ADD, 3'd3, 16'h0040, 32'h3F800000, 32'h3F800000, 1'b0);
    step();
    in_valid = 1'b0; rollback_en = 1'b0;
    check("rb_in_drop_ready", in_ready, 1'b1);
    check("rb_in_drop_thread", out_thread_idx, 3'd2);
    out_ready = 1'b1;
    step();
    check("rb_drained", out_valid, 1'b0);

    // Reset while stalled with both slots full
    out_ready = 1'b0;
    drive_beat(FP_ADD, 3'd4, 16'h0001, 32'h3F800000, 32'h3F800000, 1'b0);
    step();
    drive_beat(FP_ADD, 3'd6, 16'h0002, 32'h3F800000, 32'h3F800000, 1'b0);
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_stall_valid", out_valid, 1'b0);
    check("rst_stall_ready", in_ready, 1'b1);
    step();
    reset = 1'b0;
    step();
    check("rst_stall_after", out_valid, 1'b0);

    // Half precision: 1.0 + 2.0
    h_in_valid = 1'b1; h_in_op = FP_ADD; h_in_operand1 = 16'h3C00; h_in_operand2 = 16'h4000;
    step();
    h_in_valid = 1'b0;
    check("h_valid", h_out_valid, 1'b1);
    check("h_add_exp", h_add_exp, 5'd16);
    check("h_shift", h_align_shift, 4'd1);
    check("h_sig_le", h_sig_le, 11'h400);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
